// File: rtl/timer_control_fsm.sv
// Sequencer for a saturating timeout counter: arms it, feeds prescaled ticks,
// watches timeout and hands completion to control via done/ack. Optional: TIMER_WATCHDOG_EN.
module timer_control_fsm #(
  parameter int PRESCALE   = 4,
  parameter int WDOG_TICKS = 6
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       abort,
  input  logic       timeout,
  input  logic       ack,
  output logic       counter_tick,
  output logic       counter_clear,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] elapsed
);

  localparam int            PS_W    = 8;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [2:0]    EL_MAX  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  if (PRESCALE < 2 || PRESCALE > 255) begin : g_bad_prescale
    $error("timer_control_fsm: PRESCALE out of range 2..255");
  end
  if (WDOG_TICKS < 5 || WDOG_TICKS > 7) begin : g_bad_wdog
    $error("timer_control_fsm: WDOG_TICKS out of range 5..7");
  end

  state_t          r_state;
  state_t          w_next;
  logic [PS_W-1:0] r_prescale;
  logic            r_tick;
  logic            r_abort_clr;
  logic [2:0]      r_elapsed;
  logic            w_run_stay;
  logic            w_abort_exit;
  logic            w_wdog_exit;
  logic            w_tick_next;

  // Watchdog fires on the registered tick count, only when the counter has not timed out.
`ifdef TIMER_WATCHDOG_EN
  localparam logic [2:0] WDOG_VAL = 3'(WDOG_TICKS);
  logic w_wdog_hit;
  assign w_wdog_hit = (r_elapsed == WDOG_VAL);
`else
  logic w_wdog_hit;
  assign w_wdog_hit = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    w_run_stay   = 1'b0;
    w_abort_exit = 1'b0;
    w_wdog_exit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ARM;
      end
      S_ARM: begin
        w_next = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          w_next       = S_IDLE;
          w_abort_exit = 1'b1;
        end else if (timeout) begin
          w_next = S_DONE;
        end else if (w_wdog_hit) begin
          w_next      = S_DONE;
          w_wdog_exit = 1'b1;
        end else begin
          w_run_stay = 1'b1;
        end
      end
      S_DONE: begin
        if (ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A tick is only launched if the FSM stays in RUN across the edge.
  assign w_tick_next = w_run_stay && (r_prescale == PS_LAST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= S_IDLE;
      r_tick      <= 1'b0;
      r_abort_clr <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tick      <= w_tick_next;
      r_abort_clr <= w_abort_exit;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_prescale <= '0;
      r_elapsed  <= '0;
    end else begin
      case (r_state)
        S_ARM: begin
          r_prescale <= '0;
          r_elapsed  <= '0;
        end
        S_RUN: begin
          if (r_prescale == PS_LAST) r_prescale <= '0;
          else                       r_prescale <= r_prescale + PS_W'(1);
          if (w_abort_exit)                       r_elapsed <= '0;
          else if (r_tick && r_elapsed != EL_MAX) r_elapsed <= r_elapsed + 3'd1;
        end
        default: begin
          r_prescale <= r_prescale;
          r_elapsed  <= r_elapsed;
        end
      endcase
    end
  end

`ifdef TIMER_WATCHDOG_EN
  logic r_err;
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                  r_err <= 1'b0;
    else if (r_state == S_ARM)  r_err <= 1'b0;
    else if (w_wdog_exit)       r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Outputs are flops or decodes of the state register only.
  assign counter_tick  = r_tick;
  assign counter_clear = (r_state == S_ARM) || r_abort_clr;
  assign busy          = (r_state == S_ARM) || (r_state == S_RUN);
  assign done          = (r_state == S_DONE);
  assign elapsed       = r_elapsed;

endmodule

// File: tb/tb_timer_control_fsm.sv
// Directed bench for timer_control_fsm with a behavioural model of the timeout counter.
module tb_timer_control_fsm;

  logic       clock = 1'b0;
  logic       clear, start, abort, ack;
  wire        timeout;
  logic       counter_tick, counter_clear, busy, done, err;
  logic [2:0] elapsed;

  int n_chk  = 0;
  int n_pass = 0;

  logic       tmode  = 1'b0;
  logic       tforce = 1'b0;
  logic [2:0] mcnt;
  logic       m_to;
  logic [7:0] outs;

  timer_control_fsm #(.PRESCALE(4), .WDOG_TICKS(6)) dut (
    .clock(clock), .clear(clear), .start(start), .abort(abort),
    .timeout(timeout), .ack(ack), .counter_tick(counter_tick),
    .counter_clear(counter_clear), .busy(busy), .done(done),
    .err(err), .elapsed(elapsed)
  );

  always #5 clock = ~clock;

  // Counter model: saturates at 4, visible in the same cycle as the tick.
  always @(posedge clock or posedge clear) begin
    if (clear)                             mcnt <= 3'd0;
    else if (counter_clear)                mcnt <= 3'd0;
    else if (counter_tick && mcnt < 3'd4)  mcnt <= mcnt + 3'd1;
  end
  assign m_to    = (mcnt >= 3'd4) || (mcnt == 3'd3 && counter_tick);
  assign timeout = tmode ? tforce : m_to;
  assign outs    = {counter_tick, counter_clear, busy, done, err, elapsed};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic run_to_done(input int want_lat);
    int k;
    start = 1'b1; step(1); start = 1'b0;
    k = 0;
    while (!done && k < 60) begin step(1); k++; end
    chk("done latency", k, want_lat);
  endtask

  task automatic abort_out();
    abort = 1'b1; step(1); abort = 1'b0; step(1);
    chk("cleanup idle", {busy, done}, 2'b00);
  endtask

  typedef struct {
    int         n;
    logic       st;
    logic       ab;
    logic       ak;
    logic [7:0] exp;  // {tick, clr, busy, done, err, elapsed[2:0]}
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL global time limit: got expired, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    int bad, nt, last, badgap, k;

    tbl[0]  = '{1, 1'b1, 1'b0, 1'b0, 8'b0110_0000};  // ARM
    tbl[1]  = '{1, 1'b0, 1'b0, 1'b0, 8'b0010_0000};  // RUN cycle 0
    tbl[2]  = '{3, 1'b0, 1'b0, 1'b0, 8'b0010_0000};  // cycle 3
    tbl[3]  = '{1, 1'b0, 1'b0, 1'b0, 8'b1010_0000};  // cycle 4, tick 1
    tbl[4]  = '{1, 1'b0, 1'b0, 1'b0, 8'b0010_0001};  // cycle 5
    tbl[5]  = '{3, 1'b0, 1'b0, 1'b0, 8'b1010_0001};  // cycle 8, tick 2
    tbl[6]  = '{1, 1'b0, 1'b0, 1'b0, 8'b0010_0010};  // cycle 9
    tbl[7]  = '{7, 1'b0, 1'b0, 1'b0, 8'b1010_0011};  // cycle 16, tick 4
    tbl[8]  = '{1, 1'b0, 1'b0, 1'b0, 8'b0001_0100};  // DONE after edge 18
    tbl[9]  = '{3, 1'b1, 1'b0, 1'b0, 8'b0001_0100};  // start ignored in DONE
    tbl[10] = '{1, 1'b0, 1'b0, 1'b1, 8'b0000_0100};  // ack -> IDLE
    tbl[11] = '{2, 1'b0, 1'b0, 1'b0, 8'b0000_0100};  // stays IDLE

    clear = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
    step(2);
    chk("reset outputs", outs, 8'h00);
    @(negedge clock); clear = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; ack = tbl[i].ak;
      step(tbl[i].n);
      chk($sformatf("nominal[%0d]", i), outs, tbl[i].exp);
    end
    start = 1'b0; ack = 1'b0;

    // Abort in the cycle after the 2nd tick
    start = 1'b1; step(1); start = 1'b0;
    step(10);
    chk("abort pre", outs, 8'b0010_0010);
    abort = 1'b1; step(1); abort = 1'b0;
    chk("abort exit", outs, 8'b0100_0000);
    step(1);
    chk("abort clr once", outs, 8'b0000_0000);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (counter_tick || done || counter_clear || busy) bad++;
    end
    chk("abort quiet", bad, 0);

    // timeout and abort together: abort wins
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    tmode = 1'b1; tforce = 1'b1; abort = 1'b1;
    step(1);
    chk("abort beats timeout", outs, 8'b0100_0000);
    abort = 1'b0; tmode = 1'b0; tforce = 1'b0;
    step(1);
    chk("abort beats timeout idle", outs, 8'b0000_0000);

    // start and ack together in DONE
    run_to_done(18);
    start = 1'b1; ack = 1'b1; step(1);
    chk("start+ack idle", outs, 8'b0000_0100);
    ack = 1'b0; step(1);
    chk("restart arm", outs[7:4], 4'b0110);
    start = 1'b0; step(1);
    chk("restart run0", outs, 8'b0010_0000);
    abort_out();

    // ack withheld for 10 cycles with start pulses
    run_to_done(18);
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      step(1);
      chk($sformatf("hold[%0d]", i), {done, busy, err, elapsed}, 6'b10_0_100);
    end
    start = 1'b0; ack = 1'b1; step(1); ack = 1'b0;
    chk("hold release", outs, 8'b0000_0100);

    // clear between edges after 3 ticks
    start = 1'b1; step(1); start = 1'b0;
    step(14);
    chk("pre clear", outs, 8'b0010_0011);
    @(negedge clock); clear = 1'b1; #1;
    chk("clear async", outs, 8'b0000_0000);
    @(negedge clock); clear = 1'b0;
    step(1);
    chk("clear idle", outs, 8'b0000_0000);
    start = 1'b1; step(1); start = 1'b0;
    chk("rearm", outs, 8'b0110_0000);
    step(5);
    chk("rearm tick1", outs, 8'b1010_0000);
    step(1);
    chk("rearm el1", outs, 8'b0010_0001);
    abort_out();

    // timeout tied low
    tmode = 1'b1; tforce = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
`ifdef TIMER_WATCHDOG_EN
    k = 0;
    while (!done && k < 60) begin step(1); k++; end
    chk("wdog latency", k, 27);
    chk("wdog done", {done, busy, err, elapsed}, 6'b10_1_110);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("wdog ack", {busy, done}, 2'b00);
    tmode = 1'b0;
`else
    step(40);
    chk("nowdog sat", {busy, done, err, elapsed}, 6'b10_0_111);
    nt = 0; last = -1; badgap = 0;
    for (int c = 0; c < 16; c++) begin
      step(1);
      if (counter_tick) begin
        if (last >= 0 && c - last != 4) badgap++;
        last = c;
        nt++;
      end
      if (!busy || done || elapsed != 3'd7) badgap++;
    end
    chk("nowdog ticks", nt, 4);
    chk("nowdog spacing", badgap, 0);
    tmode = 1'b0;
    abort_out();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_control_fsm.md
# timer_control_fsm

Sequencer that sits directly upstream of the saturating non-recycling timeout counter in the timer-input/control path. It arms the counter with a one-cycle clear, feeds it prescaled single-cycle count pulses, watches its timeout flag, and reports completion to the control logic over a done/ack handshake. One instance drives one counter.

## Interface

- PRESCALE, 4: clock cycles per counter_tick pulse; legal range 2..255.
- WDOG_TICKS, 6: tick count at which the watchdog forces completion; legal range 5..7; used only with TIMER_WATCHDOG_EN.

- clock  in  1  system clock; all state changes on its rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  level request for a timed interval; sampled only in IDLE.
- abort  in  1  cancels an interval; sampled only in RUN.
- timeout  in  1  counter output, high once the counter reaches 4.
- ack  in  1  consumer acknowledge of done; sampled only in DONE.
- counter_tick  out  1  one-cycle count pulse to the counter clock input.
- counter_clear  out  1  clear to the counter.
- busy  out  1  high in ARM and RUN.
- done  out  1  high in DONE.
- err  out  1  watchdog completion flag; valid while done is high.
- elapsed  out  3  ticks issued since the last ARM; saturates at 7.

## Operation

- States: IDLE, ARM, RUN, DONE.
- IDLE: start=1 -> ARM.
- ARM: exactly one cycle. counter_clear=1, prescaler<=0, elapsed<=0, err<=0. Always -> RUN.
- RUN: the prescaler counts 0..PRESCALE-1 and wraps. counter_tick is a flop, set at the edge that ends a cycle with prescaler==PRESCALE-1. elapsed increments (saturating at 7) at the edge that ends each cycle with counter_tick=1.
- RUN exit priority, highest first:
  - abort=1 -> IDLE. counter_clear pulses in the first IDLE cycle; elapsed<=0.
  - timeout=1 -> DONE, err stays 0.
  - Watchdog (macro only): elapsed==WDOG_TICKS and timeout=0 -> DONE, err<=1.
- Whenever RUN is exited, no counter_tick is issued in the exit cycle or afterwards.
- DONE: done=1. ack=1 -> IDLE. start is ignored in DONE, including when start and ack are high in the same cycle. elapsed and err hold their values until the next ARM.
- clear asserted in any state: IDLE immediately; prescaler, elapsed, err and every output go to 0.

## Timing

- Reset value of every output is 0.
- Every output is a flop or a decode of registered state; there is no combinational path from any input to any output.
- Edge 0 samples start in IDLE. The ARM cycle (counter_clear=1) follows edge 0. RUN cycle 0 begins after edge 1.
- Tick n is high in RUN cycle n*PRESCALE.
- The counter updates on the tick rising edge, so timeout is visible in the same cycle as the tick. The FSM samples timeout at the end of that cycle.
- With PRESCALE=4, a correct counter and no abort: the 4th tick is in RUN cycle 16, done rises after edge 18, and elapsed=4.
- Exiting DONE takes one edge from ack sampled high. A new start is accepted no earlier than the following edge.

## Configuration

- TIMER_WATCHDOG_EN defined: the watchdog exit is compiled in, and err can go high.
- TIMER_WATCHDOG_EN undefined: err is tied to 0. RUN exits only on timeout or abort. Ticks continue indefinitely, with elapsed saturated at 7.

## Test plan

- Nominal, PRESCALE=4, bench models the counter: start pulse -> counter_clear high 1 cycle after edge 0; ticks 4 clocks apart; done high after edge 18; elapsed=4; err=0; ack -> IDLE with busy=0.
- Abort: abort=1 in the cycle after the 2nd tick -> IDLE next edge, counter_clear pulses once, elapsed=0, no further ticks, done never rises.
- Simultaneous events: timeout=1 and abort=1 in the same RUN cycle -> IDLE, abort wins, done=0. In DONE, start=1 and ack=1 together -> IDLE, no ARM on that edge.
- Handshake hold: ack withheld 10 cycles -> done, elapsed=4 and err stay stable; start pulses during DONE are ignored.
- Reset mid-RUN: clear asserted between edges after 3 ticks -> all outputs 0 immediately, state IDLE, next start re-arms from elapsed=0.
- Watchdog, timeout tied 0, PRESCALE=4:
  - With TIMER_WATCHDOG_EN: done=1, err=1, elapsed=6.
  - Without it: busy stays 1, elapsed saturates at 7, ticks continue every 4 clocks.
